// File: rtl/sync_pkg.sv
// Shared types and register map for the sync trigger controller.
package sync_pkg;

   // Encodings are visible to the host in STATUS[4:2]
   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      FG_WAIT  = 3'd1,
      FG_DLY   = 3'd2,
      TRIG_DLY = 3'd3,
      PULSE    = 3'd4
   } state_t;

   localparam logic [2:0] REG_FG_DELAY    = 3'd0;
   localparam logic [2:0] REG_TRIG_DELAY  = 3'd1;
   localparam logic [2:0] REG_PULSE_WIDTH = 3'd2;
   localparam logic [2:0] REG_REPEAT      = 3'd3;
   localparam logic [2:0] REG_FG_TIMEOUT  = 3'd4;
   localparam logic [2:0] REG_STATUS      = 3'd5;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
module sync_edge_detect (
   input  logic clock,
   input  logic reset,
   input  logic sig,
   output logic rise
);

   logic s1, s2, q, q_d;

   // q/q_d retime the synchronised level so rise lands 3 cycles after first sample
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         q    <= 1'b0;
         q_d  <= 1'b0;
         rise <= 1'b0;
      end else begin
         s1   <= sig;
         s2   <= s1;
         q    <= s2;
         q_d  <= q;
         rise <= q & ~q_d;
      end
   end

endmodule

// File: rtl/sync_trigger_controller.sv
// FG-synchronised detector trigger sequencer with a small config register file.
module sync_trigger_controller
   import sync_pkg::*;
#(
   parameter int          CNT_W          = 32,
   parameter int unsigned FG_DELAY_DEF   = 100_000,
   parameter int unsigned TRIG_DELAY_DEF = 350_000,
   parameter int unsigned PULSE_W_DEF    = 5,
   parameter int unsigned REPEAT_DEF     = 10,
   parameter int unsigned FG_TIMEOUT_DEF = 1_000_000
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cfg_we,
   input  logic [2:0]       cfg_addr,
   input  logic [CNT_W-1:0] cfg_wdata,
   output logic [CNT_W-1:0] cfg_rdata,
   input  logic             start_signal,
   input  logic             abort,
   input  logic             fg_signal,
   output logic             detector_trigger,
   output logic             busy,
   output logic             done,
   output logic             timeout_err,
   output logic [CNT_W-1:0] pulse_count
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   function automatic logic [CNT_W-1:0] max1(input logic [CNT_W-1:0] v);
      return (v == '0) ? ONE : v;
   endfunction

   logic [CNT_W-1:0] fg_delay_r, trig_delay_r, pulse_w_r, repeat_r, fg_timeout_r;
   logic [CNT_W-1:0] cnt, lim, lim_nxt, rep;
   state_t           state, nxt;
   logic             fg_rise, hit, ld, inc, start_run, pulse_end, set_to;

   sync_edge_detect u_fg_edge (
      .clock (clock),
      .reset (reset),
      .sig   (fg_signal),
      .rise  (fg_rise)
   );

   assign busy = (state != IDLE);
   assign hit  = ((cnt + ONE) == lim);

   always_comb begin
      nxt       = state;
      ld        = 1'b0;
      lim_nxt   = '0;
      inc       = 1'b0;
      start_run = 1'b0;
      pulse_end = 1'b0;
      set_to    = 1'b0;
      case (state)
         IDLE: if (start_signal && !abort) begin
            nxt       = FG_WAIT;
            start_run = 1'b1;
            ld        = 1'b1;
            lim_nxt   = fg_timeout_r;
         end
         FG_WAIT: begin
            if (fg_rise) begin
               nxt     = FG_DLY;
               ld      = 1'b1;
               lim_nxt = max1(fg_delay_r);
            end else if (lim != '0 && hit) begin
               nxt    = IDLE;
               set_to = 1'b1;
            end else inc = 1'b1;
         end
         FG_DLY: begin
            if (hit) begin
               nxt     = TRIG_DLY;
               ld      = 1'b1;
               lim_nxt = max1(trig_delay_r);
            end else inc = 1'b1;
         end
         TRIG_DLY: begin
            if (hit) begin
               nxt     = PULSE;
               ld      = 1'b1;
               lim_nxt = max1(pulse_w_r);
            end else inc = 1'b1;
         end
         PULSE: begin
            if (hit) begin
               pulse_end = 1'b1;
               if (rep == ONE) nxt = IDLE;
               else begin
                  nxt     = FG_WAIT;
                  ld      = 1'b1;
                  lim_nxt = fg_timeout_r;
               end
            end else inc = 1'b1;
         end
         default: nxt = IDLE;
      endcase
      // abort overrides every other action, leaving counts and flags untouched
      if (state != IDLE && abort) begin
         nxt       = IDLE;
         ld        = 1'b0;
         inc       = 1'b0;
         pulse_end = 1'b0;
         set_to    = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state            <= IDLE;
         cnt              <= '0;
         lim              <= '0;
         rep              <= '0;
         pulse_count      <= '0;
         timeout_err      <= 1'b0;
         detector_trigger <= 1'b0;
         done             <= 1'b0;
      end else begin
         state <= nxt;
         if (ld) begin
            cnt <= '0;
            lim <= lim_nxt;
         end else if (inc && cnt != '1) cnt <= cnt + ONE;
         if (start_run) begin
            pulse_count <= '0;
            timeout_err <= 1'b0;
            rep         <= max1(repeat_r);
         end
         if (set_to) timeout_err <= 1'b1;
         if (pulse_end) begin
            pulse_count <= pulse_count + ONE;
            rep         <= rep - ONE;
         end
         detector_trigger <= (nxt == PULSE);
         done             <= pulse_end && (rep == ONE);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         fg_delay_r   <= CNT_W'(FG_DELAY_DEF);
         trig_delay_r <= CNT_W'(TRIG_DELAY_DEF);
         pulse_w_r    <= CNT_W'(PULSE_W_DEF);
         repeat_r     <= CNT_W'(REPEAT_DEF);
         fg_timeout_r <= CNT_W'(FG_TIMEOUT_DEF);
         cfg_rdata    <= '0;
      end else begin
         if (cfg_we && !busy) begin
            case (cfg_addr)
               REG_FG_DELAY:    fg_delay_r   <= cfg_wdata;
               REG_TRIG_DELAY:  trig_delay_r <= cfg_wdata;
               REG_PULSE_WIDTH: pulse_w_r    <= cfg_wdata;
               REG_REPEAT:      repeat_r     <= cfg_wdata;
               REG_FG_TIMEOUT:  fg_timeout_r <= cfg_wdata;
               default: ;
            endcase
         end
         case (cfg_addr)
            REG_FG_DELAY:    cfg_rdata <= fg_delay_r;
            REG_TRIG_DELAY:  cfg_rdata <= trig_delay_r;
            REG_PULSE_WIDTH: cfg_rdata <= pulse_w_r;
            REG_REPEAT:      cfg_rdata <= repeat_r;
            REG_FG_TIMEOUT:  cfg_rdata <= fg_timeout_r;
            REG_STATUS:      cfg_rdata <= {{(CNT_W-5){1'b0}}, state, timeout_err, busy};
            default:         cfg_rdata <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_sync_trigger_controller.sv
// Self-checking bench: register table plus multi-cycle run/abort/timeout/reset sequences.
module tb_sync_trigger_controller;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_addr = 3'd0;
   logic [31:0] cfg_wdata = '0;
   logic [31:0] cfg_rdata;
   logic        start_signal = 1'b0;
   logic        abort = 1'b0;
   logic        fg_signal = 1'b0;
   logic        detector_trigger, busy, done, timeout_err;
   logic [31:0] pulse_count;

   sync_trigger_controller dut (
      .clock            (clock),
      .reset            (reset),
      .cfg_we           (cfg_we),
      .cfg_addr         (cfg_addr),
      .cfg_wdata        (cfg_wdata),
      .cfg_rdata        (cfg_rdata),
      .start_signal     (start_signal),
      .abort            (abort),
      .fg_signal        (fg_signal),
      .detector_trigger (detector_trigger),
      .busy             (busy),
      .done             (done),
      .timeout_err      (timeout_err),
      .pulse_count      (pulse_count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        we;
      logic [2:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;

   vec_t        tbl[20];
   logic [31:0] defs[5];
   int          vecs = 0, errs = 0;
   int          cyc = 0, rises = 0, dones = 0, pw = 0, exp_pw = 2;
   int          last_rise = 0, done_cyc = 0;
   logic        trig_q = 1'b0;
   int          exp_q[$];
   logic [31:0] rd_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // one clock; also tracks trigger rise latency/width and done pulses
   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
      if (detector_trigger && !trig_q) begin
         rises++;
         last_rise = cyc;
         pw = 1;
         if (exp_q.size() == 0) chk("trig_unexpected", 32'd1, 32'd0);
         else chk("trig_latency", cyc, exp_q.pop_front());
      end else if (detector_trigger) pw++;
      else if (trig_q) chk("trig_width", pw, exp_pw);
      if (done) begin
         dones++;
         done_cyc = cyc;
      end
      trig_q = detector_trigger;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
      step();
      cfg_we = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] exp);
      cfg_addr = a;
      rd_q.push_back(exp);
      step();
      chk($sformatf("rd_a%0d", a), cfg_rdata, rd_q.pop_front());
   endtask

   task automatic start();
      start_signal = 1'b1;
      step();
      start_signal = 1'b0;
   endtask

   // fg high for hi cycles, then low for gap; accepted edges trigger 14 cycles after first sample
   task automatic fg_pulse(input bit accepted, input int hi, input int gap);
      fg_signal = 1'b1;
      if (accepted) exp_q.push_back(cyc + 1 + 14);
      run(hi);
      fg_signal = 1'b0;
      run(gap);
   endtask

   task automatic chk_outs_zero(input string nm);
      chk({nm, "_trig"}, {31'd0, detector_trigger}, 32'd0);
      chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
      chk({nm, "_done"}, {31'd0, done}, 32'd0);
      chk({nm, "_terr"}, {31'd0, timeout_err}, 32'd0);
      chk({nm, "_pcnt"}, pulse_count, 32'd0);
      chk({nm, "_rdata"}, cfg_rdata, 32'd0);
   endtask

   initial begin
      defs[0] = 32'd100_000; defs[1] = 32'd350_000; defs[2] = 32'd5;
      defs[3] = 32'd10;      defs[4] = 32'd1_000_000;
      for (int i = 0; i < 8; i++)
         tbl[i] = '{1'b0, 3'(i), 32'd0, (i < 5) ? defs[i] : 32'd0};
      tbl[8]  = '{1'b1, 3'd0, 32'd4,   32'd0};
      tbl[9]  = '{1'b1, 3'd1, 32'd6,   32'd0};
      tbl[10] = '{1'b1, 3'd2, 32'd2,   32'd0};
      tbl[11] = '{1'b1, 3'd3, 32'd3,   32'd0};
      tbl[12] = '{1'b1, 3'd4, 32'd0,   32'd0};
      tbl[13] = '{1'b1, 3'd5, 32'd123, 32'd0};
      tbl[14] = '{1'b0, 3'd0, 32'd0, 32'd4};
      tbl[15] = '{1'b0, 3'd1, 32'd0, 32'd6};
      tbl[16] = '{1'b0, 3'd2, 32'd0, 32'd2};
      tbl[17] = '{1'b0, 3'd3, 32'd0, 32'd3};
      tbl[18] = '{1'b0, 3'd4, 32'd0, 32'd0};
      tbl[19] = '{1'b0, 3'd5, 32'd0, 32'd0};

      // reset state
      run(2);
      chk_outs_zero("rst");
      reset = 1'b0;
      step();

      // register defaults, programming, readback
      for (int i = 0; i < 20; i++) begin
         cfg_we = tbl[i].we; cfg_addr = tbl[i].addr; cfg_wdata = tbl[i].data;
         if (!tbl[i].we) rd_q.push_back(tbl[i].exp);
         step();
         if (!tbl[i].we) chk($sformatf("tbl%0d_a%0d", i, tbl[i].addr), cfg_rdata, rd_q.pop_front());
      end
      cfg_we = 1'b0;

      // three FG-synchronised pulses
      rises = 0; dones = 0; exp_pw = 2;
      start();
      chk("run1_busy", {31'd0, busy}, 32'd1);
      run(5);
      for (int k = 0; k < 3; k++) fg_pulse(1'b1, 5, 35);
      chk("run1_rises", rises, 3);
      chk("run1_dones", dones, 1);
      chk("run1_done_cyc", done_cyc, last_rise + 2);
      chk("run1_pcnt", pulse_count, 32'd3);
      chk("run1_idle", {31'd0, busy}, 32'd0);

      // extra FG edge during TRIG_DLY is ignored
      rises = 0; dones = 0;
      start();
      run(5);
      fg_pulse(1'b1, 2, 4);
      fg_pulse(1'b0, 2, 32);
      fg_pulse(1'b1, 2, 38);
      fg_pulse(1'b1, 2, 38);
      chk("run2_rises", rises, 3);
      chk("run2_dones", dones, 1);
      chk("run2_pcnt", pulse_count, 32'd3);
      chk("run2_expq", exp_q.size(), 0);

      // FG timeout
      dones = 0;
      wr(3'd4, 32'd20);
      start();
      run(19);
      chk("to_terr_early", {31'd0, timeout_err}, 32'd0);
      chk("to_busy_early", {31'd0, busy}, 32'd1);
      step();
      chk("to_terr", {31'd0, timeout_err}, 32'd1);
      chk("to_busy", {31'd0, busy}, 32'd0);
      chk("to_dones", dones, 0);
      rd(3'd5, 32'd2);
      start();
      chk("to_clear", {31'd0, timeout_err}, 32'd0);
      abort = 1'b1;
      step();
      chk("abort_wait", {31'd0, busy}, 32'd0);
      start_signal = 1'b1;
      step();
      chk("abort_beats_start", {31'd0, busy}, 32'd0);
      start_signal = 1'b0; abort = 1'b0;

      // abort in 2nd cycle of PULSE
      wr(3'd4, 32'd0);
      wr(3'd2, 32'd5);
      dones = 0; exp_pw = 2;
      start();
      run(3);
      fg_signal = 1'b1;
      exp_q.push_back(cyc + 15);
      run(3);
      fg_signal = 1'b0;
      run(13);
      chk("ab_trig_hi", {31'd0, detector_trigger}, 32'd1);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("ab_trig_lo", {31'd0, detector_trigger}, 32'd0);
      chk("ab_busy", {31'd0, busy}, 32'd0);
      chk("ab_pcnt", pulse_count, 32'd0);
      run(2);
      chk("ab_dones", dones, 0);

      // write while busy, then reset mid-TRIG_DLY
      start();
      wr(3'd0, 32'd99);
      rd(3'd0, 32'd4);
      fg_signal = 1'b1;
      run(3);
      fg_signal = 1'b0;
      run(7);
      rd(3'd5, 32'd13);
      reset = 1'b1;
      #1;
      chk_outs_zero("rst2");
      run(2);
      reset = 1'b0;
      step();
      for (int i = 0; i < 5; i++) rd(3'(i), defs[i]);
      chk("end_expq", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/sync_trigger_controller.md
Name: sync_trigger_controller

Overview:
Programmable sequencer for the synchronization block. After a start command it waits for a frame-grabber (FG) edge, applies a programmable FG delay and trigger delay, and emits a detector trigger pulse of programmable width. It repeats this for a programmed number of frames, re-synchronising to a fresh FG edge for every repetition. Delays, pulse width, repeat count and FG timeout are set through a small register interface driven by the host-side control logic.

Parameters:
CNT_W, 32, width of all delay counters and config registers
FG_DELAY_DEF, 100_000, reset value of FG_DELAY register (cycles)
TRIG_DELAY_DEF, 350_000, reset value of TRIG_DELAY register (cycles)
PULSE_W_DEF, 5, reset value of PULSE_WIDTH register (cycles)
REPEAT_DEF, 10, reset value of REPEAT register (pulses per run)
FG_TIMEOUT_DEF, 1_000_000, reset value of FG_TIMEOUT register (cycles; 0 = disabled)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
cfg_we  in  1  register write strobe
cfg_addr  in  3  register address
cfg_wdata  in  CNT_W  write data
cfg_rdata  out  CNT_W  read data, registered, valid 1 cycle after cfg_addr
start_signal  in  1  level; sampled only in IDLE
abort  in  1  level; cancels the run
fg_signal  in  1  asynchronous FG frame signal
detector_trigger  out  1  registered trigger pulse
busy  out  1  high in any state other than IDLE
done  out  1  1-cycle pulse when a run completes normally
timeout_err  out  1  sticky; set on FG timeout, cleared on next accepted start
pulse_count  out  CNT_W  pulses issued in the current/last run

Behaviour:
- Register map: 0 FG_DELAY, 1 TRIG_DELAY, 2 PULSE_WIDTH, 3 REPEAT, 4 FG_TIMEOUT, 5 STATUS (read-only: bit0 busy, bit1 timeout_err, bits4:2 state encoding). Addresses 6–7 read 0.
- Writes to 0–4 are ignored while busy=1. Writes to 5–7 are always ignored.
- Reset: state IDLE; config registers take their *_DEF values; all outputs 0; cfg_rdata 0.
- fg_signal path: 2-flop synchroniser, then registered rising-edge detect. fg_rise asserts 3 cycles after the first clock edge that samples fg_signal=1 following a low.
- State machine:
  - IDLE:
    - start_signal=1 and abort=0 → FG_WAIT.
    - On that transition: pulse_count←0, timeout_err←0, repeat counter←max(REPEAT,1), timeout counter←0.
  - FG_WAIT:
    - fg_rise → FG_DLY.
    - Otherwise the timeout counter increments. When FG_TIMEOUT≠0 and the counter reaches FG_TIMEOUT: timeout_err←1, → IDLE. No done pulse.
  - FG_DLY: stays exactly FG_DELAY cycles (0 means 1 cycle), then → TRIG_DLY.
  - TRIG_DLY: stays exactly TRIG_DELAY cycles (0 means 1 cycle), then → PULSE.
  - PULSE:
    - detector_trigger=1 for exactly max(PULSE_WIDTH,1) cycles.
    - On exit: pulse_count+1 and repeat counter−1.
    - If the repeat counter becomes 0 → IDLE with done=1 for 1 cycle.
    - Otherwise → FG_WAIT, with the timeout counter cleared.
- Latency: detector_trigger rises FG_DELAY + TRIG_DELAY + 4 cycles after fg_signal is first sampled high (delays ≥1).
- fg_rise in FG_DLY, TRIG_DLY or PULSE is ignored, not queued. The next repetition needs a new edge seen in FG_WAIT.
- start_signal while busy is ignored.
- abort=1 in any non-IDLE state:
  - → IDLE on the next edge; detector_trigger deasserts that same edge.
  - No done pulse; pulse_count is kept; timeout_err is unchanged.
- abort and start_signal together in IDLE: abort wins and the run does not start.
- Counters never wrap: the maximum delay is 2^CNT_W−1 cycles. The comparison is on equality with the register value latched at state entry.

Decomposition:
- Package sync_pkg:
  - state enum (IDLE, FG_WAIT, FG_DLY, TRIG_DLY, PULSE) as 3 bits, with fixed encodings 0–4 exposed in STATUS.
  - register address constants (REG_FG_DELAY … REG_STATUS).
- Sub-module sync_edge_detect: 2-flop synchroniser plus registered rising-edge pulse, with the same clock/reset.
- The controller instantiates one sync_edge_detect for fg_signal.

Test Plan:
- Reset, then read addresses 0–4 → 100000, 350000, 5, 10, 1000000. STATUS=0; all outputs 0.
- Program FG_DELAY=4, TRIG_DELAY=6, PULSE_WIDTH=2, REPEAT=3, FG_TIMEOUT=0; start; 3 FG edges 40 cycles apart.
  - Expect 3 pulses, each 2 cycles wide and each rising 14 cycles after its fg_signal rise.
  - Expect done for 1 cycle after the 3rd pulse and pulse_count=3.
- Same config; an extra FG edge during TRIG_DLY → ignored; the following edge produces the next pulse; still exactly 3 pulses.
- FG_TIMEOUT=20, start, no FG edge → timeout_err=1 at cycle 20 of FG_WAIT, busy falls, no done. A new start clears timeout_err.
- abort asserted in the 2nd cycle of PULSE → detector_trigger low on the next edge, IDLE, no done, pulse_count=0.
- Write FG_DELAY=99 while busy → readback unchanged. Assert reset in mid-TRIG_DLY → all outputs 0 immediately and registers back to defaults.
